// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the sequencer's instruction/memory-handshake inputs and its
//   registered control strobes.
//
//   Signals
//     IR     [31:0]       current instruction register contents (datapath -> sequencer)
//     Cond                condition-code test for IR[31:28], meaningful in DECODE
//     MOC                 memory operation complete (memory -> sequencer)
//     State  [STATE_W-1:0] registered state code, zero-extended
//     MOV                 memory operation valid
//     RW                  1 = read, 0 = write (meaningful while MOV=1)
//     IRLd                IR load enable
//     PCLd                PC load enable
//     Fault               one-cycle fault pulse
//
//   Handshake: MOV is the request ("valid") and MOC is the completion
//   ("ready").  A memory transfer completes on the rising edge where MOV=1
//   and MOC=1.  MOV stays high and RW stays stable until that edge, or until
//   the wait limit expires.  MOC is ignored whenever MOV=0.
//
//   Modports
//     master : the sequencer (drives State and the strobes)
//     slave  : datapath/memory side (drives IR, Cond, MOC)
interface control_sequencer_if #(
  parameter int STATE_W = 10
);
  logic [31:0]        IR;
  logic               Cond;
  logic               MOC;
  logic [STATE_W-1:0] State;
  logic               MOV;
  logic               RW;
  logic               IRLd;
  logic               PCLd;
  logic               Fault;

  modport master (
    input  IR, Cond, MOC,
    output State, MOV, RW, IRLd, PCLd, Fault
  );

  modport slave (
    output IR, Cond, MOC,
    input  State, MOV, RW, IRLd, PCLd, Fault
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Instruction fetch / decode / execute control FSM for a small ARM-like
//   datapath.  It walks each instruction through its fetch, decode and
//   (optional) load/store phases and issues the datapath strobes.  Every
//   output is a registered decode of the state being entered, so nothing
//   combinational runs from an input to an output.
//
//   Parameters
//     STATE_W     width of the State output (>= 4)
//     MOC_TIMEOUT cycles allowed in a memory wait state before faulting (1..255)
//
//   Ports
//     Clk      rising-edge clock
//     Reset_n  asynchronous active-low reset
//     bus      control_sequencer_if.master (IR, Cond, MOC in; State and strobes out)
//
//   State codes (State output):
//     0 RST, 1 FADDR, 2 FINC, 3 FWAIT, 4 DECODE, 5 EXEC_DP, 6 LS_ADDR,
//     7 LS_WAIT, 8 LD_WB, 9 BASE_WB, 10 BL_LINK, 11 BRANCH, 12 FAULT.
//   The remaining codes are unreachable in normal operation.  If one of them
//   is ever entered, the FSM recovers to FADDR and all strobes are held low.
module control_sequencer #(
  parameter int STATE_W     = 10,
  parameter int MOC_TIMEOUT = 15
) (
  input logic                  Clk,
  input logic                  Reset_n,
  control_sequencer_if.master  bus
);

  typedef enum logic [STATE_W-1:0] {
    S_RST     = STATE_W'(0),
    S_FADDR   = STATE_W'(1),
    S_FINC    = STATE_W'(2),
    S_FWAIT   = STATE_W'(3),
    S_DECODE  = STATE_W'(4),
    S_EXEC_DP = STATE_W'(5),
    S_LS_ADDR = STATE_W'(6),
    S_LS_WAIT = STATE_W'(7),
    S_LD_WB   = STATE_W'(8),
    S_BASE_WB = STATE_W'(9),
    S_BL_LINK = STATE_W'(10),
    S_BRANCH  = STATE_W'(11),
    S_FAULT   = STATE_W'(12)
  } state_e;

  // The counter holds the number of MOC=0 cycles already spent in the
  // current wait state.  The wait gives up on the cycle where this count
  // would reach MOC_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MOC_TIMEOUT - 1);

  state_e      state_q;
  state_e      state_nxt;
  logic [7:0]  wait_cnt_q;

  logic        mov_q;
  logic        rw_q;
  logic        irld_q;
  logic        pcld_q;
  logic        fault_q;

  // Instruction fields used by the decoder.
  logic [2:0]  op;
  logic        wb_req;
  logic        is_load;
  logic        rd_is_pc;

  assign op       = bus.IR[27:25];
  assign is_load  = bus.IR[20];
  assign rd_is_pc = (bus.IR[15:12] == 4'hF);

  // Base write-back is needed for post-indexed accesses (P=0) and for
  // pre-indexed accesses with W=1.
  assign wb_req   = ~bus.IR[24] | bus.IR[21];

  // IR bits that do not steer this FSM.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{bus.IR[31:28], bus.IR[23:22], bus.IR[19:16],
                            bus.IR[11:8], bus.IR[6:5], bus.IR[3:0]};

  // Instruction classification, used once Cond has passed.
  // The 011 space with bit 4 set is the architecturally undefined range.
  // Without this check it would be taken as a register-offset load/store.
  function automatic state_e classify(input logic [2:0] opc,
                                      input logic       b24,
                                      input logic       b7,
                                      input logic       b4);
    state_e res;
    res = S_FAULT;
    if (opc == 3'b011 && b4) begin
      res = S_FAULT;
    end else if (opc == 3'b001 || (opc == 3'b000 && !b4)) begin
      res = S_EXEC_DP;
    end else if (opc[2:1] == 2'b01 || (opc == 3'b000 && b7 && b4)) begin
      res = S_LS_ADDR;
    end else if (opc == 3'b101) begin
      res = b24 ? S_BL_LINK : S_BRANCH;
    end else begin
      res = S_FAULT;
    end
    return res;
  endfunction

  // Next-state logic
  always_comb begin
    state_nxt = S_FADDR;
    case (state_q)
      S_RST:     state_nxt = S_FADDR;
      S_FADDR:   state_nxt = S_FINC;
      S_FINC:    state_nxt = S_FWAIT;
      S_FWAIT: begin
        // MOC on the last allowed cycle still counts as completion.
        if (bus.MOC)                      state_nxt = S_DECODE;
        else if (wait_cnt_q == WAIT_LAST) state_nxt = S_FAULT;
        else                              state_nxt = S_FWAIT;
      end
      S_DECODE: begin
        if (!bus.Cond) state_nxt = S_FADDR;
        else           state_nxt = classify(op, bus.IR[24], bus.IR[7], bus.IR[4]);
      end
      S_EXEC_DP: state_nxt = S_FADDR;
      S_LS_ADDR: state_nxt = S_LS_WAIT;
      S_LS_WAIT: begin
        if (bus.MOC) begin
          if (is_load)     state_nxt = S_LD_WB;
          else if (wb_req) state_nxt = S_BASE_WB;
          else             state_nxt = S_FADDR;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_nxt = S_FAULT;
        end else begin
          state_nxt = S_LS_WAIT;
        end
      end
      S_LD_WB:   state_nxt = wb_req ? S_BASE_WB : S_FADDR;
      S_BASE_WB: state_nxt = S_FADDR;
      S_BL_LINK: state_nxt = S_BRANCH;
      S_BRANCH:  state_nxt = S_FADDR;
      S_FAULT:   state_nxt = S_FADDR;
      default:   state_nxt = S_FADDR;
    endcase
  end

  // State, wait counter and registered strobes.  The strobes are decoded
  // from the state being entered, so they line up with State on the same
  // cycle.
  // IRLd is high for every FWAIT cycle.  The IR register captures memory
  // data on the edge where IRLd and MOC are both high, which is the
  // completing cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_RST;
      wait_cnt_q <= 8'd0;
      mov_q      <= 1'b0;
      rw_q       <= 1'b0;
      irld_q     <= 1'b0;
      pcld_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;

      // Count only while staying in a wait state.  Staying there implies
      // MOC=0.  Any other transition, including entry, clears the count.
      if ((state_q == S_FWAIT || state_q == S_LS_WAIT) && state_nxt == state_q)
        wait_cnt_q <= wait_cnt_q + 8'd1;
      else
        wait_cnt_q <= 8'd0;

      mov_q   <= (state_nxt == S_FWAIT) || (state_nxt == S_LS_WAIT);
      rw_q    <= (state_nxt == S_FWAIT) ? 1'b1 :
                 (state_nxt == S_LS_WAIT) ? is_load : 1'b0;
      irld_q  <= (state_nxt == S_FWAIT);
      pcld_q  <= (state_nxt == S_FINC) || (state_nxt == S_BRANCH) ||
                 ((state_nxt == S_EXEC_DP) && rd_is_pc);
      fault_q <= (state_nxt == S_FAULT);
    end
  end

  assign bus.State = state_q;
  assign bus.MOV   = mov_q;
  assign bus.RW    = rw_q;
  assign bus.IRLd  = irld_q;
  assign bus.PCLd  = pcld_q;
  assign bus.Fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Self-checking bench for control_sequencer.  Each instruction is expanded
//   into the per-cycle trace the architecture defines: state code, inputs to
//   present, and the expected strobes for that state.  The DUT is then
//   stepped through the trace.  Directed cases come first, followed by
//   randomized instructions and memory latencies.
module tb_control_sequencer;

  localparam int STATE_W = 10;
  localparam int T       = 15;   // MOC_TIMEOUT under test

  // State codes as defined for the State output
  localparam int C_RST = 0, C_FADDR = 1, C_FINC = 2, C_FWAIT = 3, C_DECODE = 4;
  localparam int C_EXEC = 5, C_LSADDR = 6, C_LSWAIT = 7, C_LDWB = 8, C_BASEWB = 9;
  localparam int C_BL = 10, C_BRANCH = 11, C_FAULT = 12;

  logic clk;
  logic rst_n;

  control_sequencer_if #(.STATE_W(STATE_W)) bus ();

  control_sequencer #(.STATE_W(STATE_W), .MOC_TIMEOUT(T)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]  st;
    logic        moc;
    logic        cond;
    logic [31:0] ir;
    logic        rst_here;
  } step_t;

  step_t plan_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected strobes for a state, as {MOV, RW, IRLd, PCLd, Fault}
  function automatic logic [4:0] exp_strobes(input int st, input logic [31:0] ir);
    logic mov, rw, irld, pcld, flt;
    mov  = (st == C_FWAIT) || (st == C_LSWAIT);
    rw   = (st == C_FWAIT) ? 1'b1 : ((st == C_LSWAIT) ? ir[20] : 1'b0);
    irld = (st == C_FWAIT);
    pcld = (st == C_FINC) || (st == C_BRANCH) || (st == C_EXEC && ir[15:12] == 4'hF);
    flt  = (st == C_FAULT);
    return {mov, rw, irld, pcld, flt};
  endfunction

  // Where DECODE goes for a passed condition
  function automatic int after_decode(input logic [31:0] ir);
    logic [2:0] op;
    op = ir[27:25];
    if (op == 3'b011 && ir[4]) return C_FAULT;     // undefined space
    if (op == 3'b001) return C_EXEC;
    if (op == 3'b000) return (!ir[4]) ? C_EXEC : (ir[7] ? C_LSADDR : C_FAULT);
    if (op[2:1] == 2'b01) return C_LSADDR;
    if (op == 3'b101) return ir[24] ? C_BL : C_BRANCH;
    return C_FAULT;
  endfunction

  // ---------------- driver / plan construction ----------------
  task automatic push(input int st, input logic moc, input logic cond,
                      input logic [31:0] ir, input bit rh);
    step_t s;
    s.st = 4'(st);
    s.moc = moc;
    s.cond = cond;
    s.ir = ir;
    s.rst_here = rh;
    plan_q.push_back(s);
  endtask

  // Push a wait-state stretch.  MOC arrives after d idle cycles.  d >= T
  // means it never arrives and the wait times out into FAULT.  A reset can
  // be planted at wait cycle rst_k.  stop=1 means the instruction ended here.
  task automatic add_wait(input int st, input int d, input logic cond,
                          input logic [31:0] ir, input int rst_k, output bit stop);
    stop = 1'b0;
    for (int k = 0; k < T; k++) begin
      push(st, (k == d), cond, ir, (k == rst_k));
      if (k == rst_k) begin
        stop = 1'b1;
        return;
      end
      if (k == d) return;
    end
    push(C_FAULT, 1'($urandom_range(0, 1)), cond, ir, 1'b0);
    stop = 1'b1;
  endtask

  task automatic add_instr(input logic [31:0] ir, input logic cond,
                           input int df, input int dl, input int rst_k);
    bit stop;
    int nxt;
    push(C_FADDR, 1'($urandom_range(0, 1)), cond, ir, 1'b0);
    push(C_FINC,  1'($urandom_range(0, 1)), cond, ir, 1'b0);
    add_wait(C_FWAIT, df, cond, ir, -1, stop);
    if (stop) return;
    push(C_DECODE, 1'($urandom_range(0, 1)), cond, ir, 1'b0);
    if (!cond) return;
    nxt = after_decode(ir);
    case (nxt)
      C_EXEC, C_FAULT: push(nxt, 1'($urandom_range(0, 1)), cond, ir, 1'b0);
      C_BL: begin
        push(C_BL, 1'b0, cond, ir, 1'b0);
        push(C_BRANCH, 1'b0, cond, ir, 1'b0);
      end
      C_BRANCH: push(C_BRANCH, 1'b0, cond, ir, 1'b0);
      default: begin
        push(C_LSADDR, 1'($urandom_range(0, 1)), cond, ir, 1'b0);
        add_wait(C_LSWAIT, dl, cond, ir, rst_k, stop);
        if (stop) return;
        if (ir[20]) push(C_LDWB, 1'b0, cond, ir, 1'b0);
        if (!ir[24] || ir[21]) push(C_BASEWB, 1'b0, cond, ir, 1'b0);
      end
    endcase
  endtask

  // Step the DUT through the plan.  Entered at a negedge: compare the
  // current cycle, present its inputs, then move to the next negedge.
  task automatic run_plan();
    step_t s;
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      bus.IR   = s.ir;
      bus.MOC  = s.moc;
      bus.Cond = s.cond;
      check_val("state", 32'(bus.State), 32'(s.st));
      check_val("strobes", 32'({bus.MOV, bus.RW, bus.IRLd, bus.PCLd, bus.Fault}),
                32'(exp_strobes(int'(s.st), s.ir)));
      if (s.rst_here) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_state", 32'(bus.State), 32'(C_RST));
        check_val("async_rst_strobes",
                  32'({bus.MOV, bus.RW, bus.IRLd, bus.PCLd, bus.Fault}), 32'd0);
        @(negedge clk);
        check_val("held_rst_state", 32'(bus.State), 32'(C_RST));
        rst_n = 1'b1;
        continue;   // the following RST step is checked at this same negedge
      end
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ir;
    int pick, r;
    rst_n    = 1'b0;
    bus.IR   = 32'd0;
    bus.MOC  = 1'b1;
    bus.Cond = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_state", 32'(bus.State), 32'(C_RST));
    check_val("reset_strobes", 32'({bus.MOV, bus.RW, bus.IRLd, bus.PCLd, bus.Fault}), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    push(C_RST, 1'b0, 1'b1, 32'd0, 1'b0);
    add_instr(32'hE0812003, 1'b1, 0, 0, -1);      // ADD: 1,2,3,4,5
    add_instr(32'hE5912004, 1'b1, 0, 2, -1);      // LDR pre, no W: 6,7,7,7,8
    add_instr(32'hE4812004, 1'b1, 1, 0, -1);      // STR post: 6,7,9
    add_instr(32'hE5B12004, 1'b1, 0, 1, -1);      // LDR pre with W: 8,9
    add_instr(32'hEB000010, 1'b1, 0, 0, -1);      // BL: 10,11
    add_instr(32'hEB000010, 1'b0, 0, 0, -1);      // skipped: 4,1
    add_instr(32'hE1A0F00E, 1'b1, 0, 0, -1);      // MOV PC,LR: PCLd in EXEC_DP
    add_instr(32'hE0812003, 1'b1, T, 0, -1);      // fetch timeout -> FAULT
    add_instr(32'hE0812003, 1'b1, T - 1, 0, -1);  // MOC on last wait cycle
    add_instr(32'hE7F000F0, 1'b1, 0, 0, -1);      // undefined -> FAULT
    add_instr(32'hE5912004, 1'b1, 0, T, -1);      // load/store timeout
    add_instr(32'hE5912004, 1'b1, 0, 9, 2);       // reset asserted mid LS_WAIT
    push(C_RST, 1'b0, 1'b1, 32'd0, 1'b0);
    add_instr(32'hE0812003, 1'b1, T, 0, -1);      // counter must be clear after reset
    run_plan();

    // Randomized instructions and latencies
    for (int n = 0; n < 200; n++) begin
      ir   = $urandom;
      pick = $urandom_range(0, 6);
      case (pick)
        1: ir[27:25] = 3'b001;
        2: ir[27:26] = 2'b01;
        3: ir[27:25] = 3'b101;
        4: ir[27:25] = 3'b000;
        5: begin ir[27:25] = 3'b001; ir[15:12] = 4'hF; end
        6: begin ir[27:25] = 3'b000; ir[7] = 1'b1; ir[4] = 1'b1; end
        default: ;
      endcase
      r = $urandom_range(0, 9);
      add_instr(ir, ($urandom_range(0, 7) != 0),
                (r == 0) ? T : ((r == 1) ? T - 1 : $urandom_range(0, 3)),
                (r == 2) ? T : ((r == 3) ? T - 1 : $urandom_range(0, 3)),
                -1);
    end
    run_plan();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
